alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that time-shares the single 32-bit ALU of the multicycle core between requester 0 (EXU main operation) and requester 1 (branch/compare path). It accepts one request at a time over a valid/ready handshake, latches the operands, drives the ALU for one cycle, registers the result and returns it to the winning requester over a second valid/ready handshake. It sits between IDU/EXU control and the ALU instance.

---
 rtl/alu_share_arb_if.sv | 58 +++++
 rtl/alu_share_arb.sv | 135 +++++++++++++
 tb/tb_alu_share_arb.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - request/response and ALU-side signal bundle for alu_share_arb
//
// Groups the two requester handshakes, the two response handshakes and the
// shared ALU connection.
//   slave  : seen by alu_share_arb (accepts requests, returns responses, drives the ALU)
//   master : seen by the requesters and the ALU instance
//
// Signals (N = 0, 1):
//   reqN_valid/reqN_ready/reqN_op/reqN_a/reqN_b  request handshake and payload
//   rspN_valid/rspN_ready/rspN_res               response handshake and result
//   alu_op/alu_num1/alu_num2                     operands to the shared ALU
//   alu_res                                      combinational result from the ALU

interface alu_share_arb_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_res;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_res;

    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_num1;
    logic [DATA_W-1:0] alu_num2;
    logic [DATA_W-1:0] alu_res;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  alu_res,
        output req0_ready, rsp0_valid, rsp0_res,
        output req1_ready, rsp1_valid, rsp1_res,
        output alu_op, alu_num1, alu_num2
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output alu_res,
        input  req0_ready, rsp0_valid, rsp0_res,
        input  req1_ready, rsp1_valid, rsp1_res,
        input  alu_op, alu_num1, alu_num2
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester time-sharing arbiter/sequencer for the core ALU
//
// Accepts one ALU request at a time from requester 0 (EXU) or requester 1
// (branch/compare), latches op and operands, drives the shared ALU for one
// cycle, registers the result and hands it back to the granted requester.
// Sequence: IDLE (accept) -> EXEC (ALU cycle) -> RESP (hold until taken).
// A response is valid exactly two cycles after the accept cycle.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset; discards any in-flight operation
//   bus  : alu_share_arb_if.slave (request/response handshakes, ALU connection)
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                  undefined -> fixed priority, requester 0 wins

module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              grant_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;

    logic              accept_en;
    logic              pick1;
    logic              accept;
    logic              rsp_take;

    // ------------------------------------------------------------------
    // Arbitration: pick1 selects requester 1 as winner for this cycle.
    // ------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    // Remembers which requester was granted last; starts at 1 so that the
    // first contention after reset goes to requester 0.
    logic last_grant_q;

    // On contention the requester that was not granted last wins.
    assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
`else
    assign pick1 = bus.req1_valid & ~bus.req0_valid;
`endif

    // Readies depend only on state and request valids, never on rspN_ready,
    // and stay low while reset is asserted.
    assign accept_en      = ~rst & (state == IDLE);
    assign bus.req0_ready = accept_en & bus.req0_valid & ~pick1;
    assign bus.req1_ready = accept_en & pick1;
    assign accept         = bus.req0_ready | bus.req1_ready;

    // Response is taken when the granted requester's ready is high.
    assign rsp_take = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            grant_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= pick1 ? bus.req1_op : bus.req0_op;
                        a_q     <= pick1 ? bus.req1_a  : bus.req0_a;
                        b_q     <= pick1 ? bus.req1_b  : bus.req0_b;
                        grant_q <= pick1;
`ifdef ALU_ARB_RR_EN
                        last_grant_q <= pick1;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q        <= bus.alu_res;
                    rsp0_valid_q <= ~grant_q;
                    rsp1_valid_q <= grant_q;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // ALU inputs always come from the latch so the ALU sees stable operands
    // and the request ports never reach the ALU combinationally.
    assign bus.alu_op   = op_q;
    assign bus.alu_num1 = a_q;
    assign bus.alu_num2 = b_q;

    // Both result ports share the result register; only valid is steered.
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_res   = res_q;
    assign bus.rsp1_res   = res_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard testbench for alu_share_arb

module tb_alu_share_arb;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU attached to the arbiter's ALU port.
    always_comb begin
        case (bus.alu_op)
            4'd0:    bus.alu_res = bus.alu_num1 + bus.alu_num2;
            4'd1:    bus.alu_res = bus.alu_num1 - bus.alu_num2;
            4'd2:    bus.alu_res = bus.alu_num1 ^ bus.alu_num2;
            4'd3:    bus.alu_res = bus.alu_num1 | bus.alu_num2;
            4'd4:    bus.alu_res = bus.alu_num1 & bus.alu_num2;
            4'd5:    bus.alu_res = {31'd0, $signed(bus.alu_num1) < $signed(bus.alu_num2)};
            4'd6:    bus.alu_res = bus.alu_num1 << bus.alu_num2[4:0];
            4'd7:    bus.alu_res = bus.alu_num1 >> bus.alu_num2[4:0];
            4'd8:    bus.alu_res = $unsigned($signed(bus.alu_num1) >>> bus.alu_num2[4:0]);
            4'd9:    bus.alu_res = {31'd0, bus.alu_num1 < bus.alu_num2};
            4'd10:   bus.alu_res = {31'd0, bus.alu_num1 == bus.alu_num2};
            default: bus.alu_res = 32'd0;
        endcase
    end

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] res;
        int          acc;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    logic [31:0] exp0 = '0;
    logic [31:0] exp1 = '0;
    bit          seen = 0;
    bit          in_cont = 0;
    int          r1_ready_cnt = 0;
    logic        gseq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes on accepted requests, pops and compares on taken responses.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            seen = 0;
        end else begin
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{id: 1'b0, res: exp0, acc: cyc});
                if (in_cont) gseq.push_back(1'b0);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{id: 1'b1, res: exp1, acc: cyc});
                if (in_cont) gseq.push_back(1'b1);
            end
            if (in_cont && bus.req1_ready) r1_ready_cnt++;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                check("rsp_one_hot", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
                if (sb.size() == 0) begin
                    check("stray_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        check("rsp_latency", 32'(cyc - sb[0].acc), 32'd2);
                        seen = 1;
                    end
                    if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
                        check("rsp_id", 32'(bus.rsp1_valid), 32'(sb[0].id));
                        check("rsp_res", bus.rsp1_valid ? bus.rsp1_res : bus.rsp0_res, sb[0].res);
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        bit hs = 0;
        int n  = 0;
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; exp1 = exp; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; exp0 = exp; bus.req0_valid = 1'b1;
        end
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check("accept_timeout", 32'(hs), 32'd1);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic no_stale(input string tag);
        bit stale = 0;
        repeat (6) begin
            @(negedge clk);
            stale |= bus.rsp0_valid | bus.rsp1_valid;
        end
        check(tag, 32'(stale), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'd0);
        check({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'd0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
        check({tag, "_alu_num1"}, bus.alu_num1, 32'd0);
        check({tag, "_alu_num2"}, bus.alu_num2, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req0_valid = 0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;

        // Reset state, with a request pending while reset is held.
        bus.req0_valid = 1;
        @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        check_cleared("rst");
        bus.req0_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;

        // Single ops and opcode coverage.
        send(0, 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000); drain();
        send(1, 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000); drain();
        send(1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);         drain();
        send(1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);         drain();

        // Back-to-back requests without waiting for drain.
        send(0, 4'd1, 32'd10,        32'd3,  32'd7);
        send(1, 4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
        send(0, 4'd6, 32'd1,         32'd31, 32'h8000_0000);
        send(1, 4'd7, 32'h8000_0000, 32'd31, 32'd1);
        drain();

        // Unassigned opcode.
        send(0, 4'd12, 32'd3, 32'd4, 32'd0); drain();

        // Contention from a fresh reset.
        do_reset();
        bus.req0_op = 4'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd2; exp0 = 32'd3;
        bus.req1_op = 4'd1; bus.req1_a = 32'd5; bus.req1_b = 32'd3; exp1 = 32'd2;
        gseq.delete();
        r1_ready_cnt = 0;
        in_cont = 1;
        bus.req0_valid = 1; bus.req1_valid = 1;
        repeat (14) @(posedge clk);
        #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        in_cont = 0;
        drain();
        check("cont_grant_count", 32'(gseq.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            check($sformatf("cont_grant_%0d", i), 32'(gseq[i]), 32'(i % 2));
`else
            check($sformatf("cont_grant_%0d", i), 32'(gseq[i]), 32'd0);
`endif
        end
`ifndef ALU_ARB_RR_EN
        check("cont_req1_ready", 32'(r1_ready_cnt), 32'd0);
`endif

        // Backpressure on requester 0 with requester 1 waiting.
        bus.rsp0_ready = 0;
        send(0, 4'd10, 32'h55, 32'h55, 32'd1);
        bus.req1_op = 4'd0; bus.req1_a = 32'd1; bus.req1_b = 32'd1; exp1 = 32'd2;
        bus.req1_valid = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp0_valid && n < 10);
        check("bp_valid_seen", 32'(bus.rsp0_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
            check("bp_rsp0_res", bus.rsp0_res, 32'd1);
            check("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1;
        @(negedge clk);
        check("bp_req1_ready_resp", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        check("bp_resume", 32'(bus.req1_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req1_valid = 0;
        drain();

        // Reset while in EXEC.
        send(0, 4'd0, 32'd1, 32'd1, 32'd2);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check_cleared("rst_exec");
        no_stale("rst_exec_stale");

        // Reset while in RESP.
        bus.rsp1_ready = 0;
        send(1, 4'd3, 32'hF0, 32'h0F, 32'hFF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp1_valid && n < 10);
        check("rst_resp_valid_seen", 32'(bus.rsp1_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1;
        bus.req0_op = 4'd0; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
        bus.req0_valid = 1;
        @(negedge clk);
        check("rst_resp_req0_ready", 32'(bus.req0_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        bus.req0_valid = 0;
        @(negedge clk);
        check_cleared("rst_resp");
        bus.rsp1_ready = 1;
        no_stale("rst_resp_stale");

        // Normal operation after reset.
        send(0, 4'd4, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00); drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
